// File: rtl/femto_mem_pkg.sv
// Shared types and defaults for the femto memory-port arbiter.
package femto_mem_pkg;

  localparam int AW_DEF             = 32;
  localparam int DW_DEF             = 32;
  localparam int STARVE_MAX_DEF     = 4;
  localparam int TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data requesters, with a starvation counter
// that hands the port to fetch after STARVE_MAX consecutive data wins.
module mem_arb_pick
  import femto_mem_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  input  logic decide,
  output logic pick_data
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved   = (starve_cnt == CW'(STARVE_MAX));
  assign pick_data = d_req && !(if_req && starved);

  // Counter only moves on arbitration cycles; a data win with no fetch waiting is not starvation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (decide) begin
      if (!if_req || !pick_data) begin
        starve_cnt <= '0;
      end else if (!starved) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between RV32 fetch and data requesters.
// Optional memory-wait timeout enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
  import femto_mem_pkg::*;
#(
  parameter int AW             = AW_DEF,
  parameter int DW             = DW_DEF,
  parameter int STARVE_MAX     = STARVE_MAX_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ack,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ack,
  output logic            m_req,
  output logic            m_we,
  output logic [DW/8-1:0] m_be,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata,
  input  logic            m_ready,
  output logic            busy,
  output logic            err
);

  arb_state_e    state, state_nxt;
  logic          in_idle;
  logic          start;
  logic          pick_data;
  logic          win_data;
  logic          issue_done;
  logic          timed_out;
  logic [DW-1:0] rd_val;

  assign in_idle    = (state == IDLE);
  assign start      = in_idle && (if_req || d_req);
  assign issue_done = (state == ISSUE) && (m_ready || timed_out);
  assign busy       = !in_idle;
  // Writes and timed-out accesses return zero to the requester.
  assign rd_val     = (m_ready && !m_we) ? m_rdata : '0;

  mem_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .d_req    (d_req),
    .decide   (in_idle),
    .pick_data(pick_data)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;

  assign timed_out = (state == ISSUE) && !m_ready && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      tmo_cnt <= ((state == ISSUE) && !m_ready) ? tmo_cnt + TW'(1) : '0;
      err     <= timed_out;
    end
  end
`else
  assign timed_out = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (if_req || d_req) state_nxt = ISSUE;
      ISSUE:   if (issue_done) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      win_data <= 1'b0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_be     <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      state  <= state_nxt;
      m_req  <= (state_nxt == ISSUE);
      if_ack <= issue_done && !win_data;
      d_ack  <= issue_done && win_data;
      // Memory fields are latched once at arbitration and held through ISSUE.
      if (start) begin
        win_data <= pick_data;
        if (pick_data) begin
          m_we    <= d_we;
          m_be    <= d_be;
          m_addr  <= d_addr;
          m_wdata <= d_wdata;
        end else begin
          m_we    <= 1'b0;
          m_be    <= '1;
          m_addr  <= if_addr;
          m_wdata <= '0;
        end
      end
      if (issue_done) begin
        if (win_data) d_rdata <= rd_val;
        else          if_rdata <= rd_val;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: per-cycle model compare plus directed literal checks.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, BW = 4, SMAX = 4, TMO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, d_req, d_we, m_ready;
  logic [AW-1:0] if_addr, d_addr;
  logic [BW-1:0] d_be;
  logic [DW-1:0] d_wdata, m_rdata;
  logic [DW-1:0] if_rdata, d_rdata, m_wdata;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_be;
  logic          if_ack, d_ack, m_req, m_we, busy, err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .busy(busy), .err(err)
  );

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: phase 0 waiting, 1 memory access outstanding, 2 acknowledge.
  int            ph, streak, tcnt;
  bit            md;
  logic          mwe;
  logic [BW-1:0] mbe;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mwd;
  logic          e_if_ack, e_d_ack, e_err;
  logic [DW-1:0] e_if_rd, e_d_rd;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph <= 0; streak <= 0; tcnt <= 0; md <= 0;
      mwe <= 0; mbe <= '0; maddr <= '0; mwd <= '0;
      e_if_ack <= 0; e_d_ack <= 0; e_err <= 0; e_if_rd <= '0; e_d_rd <= '0;
    end else begin
      e_if_ack <= 0; e_d_ack <= 0; e_err <= 0;
      if (ph == 0) begin
        if (d_req && !(if_req && streak == SMAX)) begin
          ph <= 1; tcnt <= 0; md <= 1;
          mwe <= d_we; mbe <= d_be; maddr <= d_addr; mwd <= d_wdata;
          streak <= if_req ? ((streak < SMAX) ? streak + 1 : SMAX) : 0;
        end else if (if_req) begin
          ph <= 1; tcnt <= 0; md <= 0;
          mwe <= 0; mbe <= '1; maddr <= if_addr; mwd <= '0;
          streak <= 0;
        end else begin
          streak <= 0;
        end
      end else if (ph == 1) begin
        if (m_ready) begin
          ph <= 2;
          if (md) begin e_d_ack <= 1; e_d_rd <= mwe ? 32'h0 : m_rdata; end
          else    begin e_if_ack <= 1; e_if_rd <= m_rdata; end
        end
`ifdef ARB_TIMEOUT_EN
        else if (tcnt == TMO - 1) begin
          ph <= 2; e_err <= 1;
          if (md) begin e_d_ack <= 1; e_d_rd <= '0; end
          else    begin e_if_ack <= 1; e_if_rd <= '0; end
        end
`endif
        tcnt <= tcnt + 1;
      end else begin
        ph <= 0;
      end
    end
  end

  bit chk_on = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", busy, ph != 0);
      check("m_req", m_req, ph == 1);
      if (ph == 1) begin
        check("m_we", m_we, mwe);
        check("m_be", m_be, mbe);
        check("m_addr", m_addr, maddr);
        if (md) check("m_wdata", m_wdata, mwd);
      end
      check("if_ack", if_ack, e_if_ack);
      check("d_ack", d_ack, e_d_ack);
      check("if_rdata", if_rdata, e_if_rd);
      check("d_rdata", d_rdata, e_d_rd);
      check("err", err, e_err);
    end
  end

  // Returns the number of negedges from call until an ack is seen.
  task automatic wait_ack(input string name, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(if_ack || d_ack) && cyc < 64);
    if (!(if_ack || d_ack)) check({name, "_ack_seen"}, if_ack | d_ack, 1);
  endtask

  // Collects grants in order while requests are held; optional d_req edits at given grant counts.
  task automatic run_grants(input string name, input string exp_s, input int drop_at, input int raise_at);
    int got = 0;
    int cyc = 0;
    string seq = "";
    while (got < exp_s.len() && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (d_ack || if_ack) begin
        seq = {seq, d_ack ? "D" : "F"};
        got++;
        if (got == drop_at)  d_req = 0;
        if (got == raise_at) d_req = 1;
      end
    end
    for (int i = 0; i < exp_s.len(); i++) begin
      byte a;
      a = (i < seq.len()) ? seq[i] : "?";
      check($sformatf("%s_grant%0d", name, i), a, exp_s[i]);
    end
    if_req = 0; d_req = 0;
  endtask

  initial begin
    int cyc;
    rst = 0; if_req = 0; d_req = 0; d_we = 0; m_ready = 0;
    if_addr = '0; d_addr = '0; d_be = '0; d_wdata = '0; m_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_m_req", m_req, 0);
    check("rst_busy", busy, 0);
    check("rst_acks", {if_ack, d_ack}, 0);
    check("rst_rdata", {if_rdata, d_rdata}, 0);
    check("rst_err", err, 0);
    rst = 1;
    chk_on = 1;
    @(negedge clk);

    // single fetch, zero-wait memory
    if_req = 1; if_addr = 32'h0000_0010; m_ready = 1; m_rdata = 32'h0000_0013;
    @(negedge clk);
    check("sf_m_req_c1", m_req, 1);
    check("sf_m_addr", m_addr, 32'h10);
    @(negedge clk);
    check("sf_if_ack_c2", if_ack, 1);
    check("sf_if_rdata", if_rdata, 32'h13);
    check("sf_d_ack", d_ack, 0);
    if_req = 0;
    @(negedge clk);
    check("sf_if_ack_once", if_ack, 0);

    // data read to load d_rdata with a nonzero value
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h200; m_rdata = 32'hA5A5_0001;
    wait_ack("drd", cyc);
    check("drd_latency", cyc, 2);
    check("drd_rdata", d_rdata, 32'hA5A5_0001);
    d_req = 0;
    @(negedge clk);

    // data store with 3-cycle memory wait; requester fields perturbed during ISSUE
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    m_ready = 0; m_rdata = 32'h55;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("st_m_req_c%0d", k), m_req, 1);
      check($sformatf("st_fields_c%0d", k), {m_we, m_be, m_addr, m_wdata}, {1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF});
      d_addr = 32'h104 + k; d_wdata = k; d_be = 4'hC; d_we = 0;
      if (k == 3) m_ready = 1;
    end
    @(negedge clk);
    check("st_d_ack", d_ack, 1);
    check("st_d_rdata", d_rdata, 0);
    d_req = 0;
    @(negedge clk);

    // contention with both requests held
    if_req = 1; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h300; if_addr = 32'h20; m_rdata = 32'h77;
    run_grants("cont", "DDDDFDDDDF", -1, -1);
    @(negedge clk);

    // d_req dropped after 3 data wins: fetch wins alone, counter restarts
    if_req = 1; d_req = 1;
    run_grants("alt", "DDDFDDDDF", 3, 4);
    @(negedge clk);

    // reset in the middle of an access
    d_req = 1; d_we = 0; m_ready = 0;
    @(negedge clk);
    check("rs_m_req_before", m_req, 1);
    @(negedge clk);
    #2 rst = 0;
    #1;
    check("rs_m_req", m_req, 0);
    check("rs_busy", busy, 0);
    check("rs_acks", {if_ack, d_ack}, 0);
    check("rs_rdata", {if_rdata, d_rdata}, 0);
    d_req = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    if_req = 1; if_addr = 32'h40; m_ready = 1; m_rdata = 32'h1234;
    wait_ack("rs_new", cyc);
    check("rs_new_latency", cyc, 2);
    check("rs_new_if_ack", if_ack, 1);
    check("rs_new_rdata", if_rdata, 32'h1234);
    if_req = 0;
    @(negedge clk);

    // memory never ready
    d_req = 1; d_we = 0; d_addr = 32'h500; m_ready = 0; m_rdata = 32'h77;
`ifdef ARB_TIMEOUT_EN
    wait_ack("tmo", cyc);
    check("tmo_latency", cyc, TMO + 1);
    check("tmo_err_ack", {err, d_ack}, 2'b11);
    check("tmo_d_rdata", d_rdata, 0);
    d_req = 0;
    @(negedge clk);
    check("tmo_err_once", err, 0);
    @(negedge clk);
    check("tmo_idle", busy, 0);
`else
    repeat (TMO + 4) @(negedge clk);
    check("notmo_m_req", m_req, 1);
    check("notmo_err", err, 0);
    check("notmo_d_ack", d_ack, 0);
    m_ready = 1;
    wait_ack("notmo", cyc);
    check("notmo_d_ack_late", d_ack, 1);
    check("notmo_d_rdata", d_rdata, 32'h77);
    d_req = 0;
    @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32: address width.
REQ-002 The block SHALL have parameter DW, default 32: data width, with byte enables of DW/8 bits.
REQ-003 The block SHALL have parameter STARVE_MAX, default 4: the number of consecutive data grants allowed while a fetch waits.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 16: the memory wait limit, used only when ARB_TIMEOUT_EN is defined.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have fetch ports:
  - if_req, input, 1 bit.
  - if_addr, input, AW bits.
  - if_rdata, output, DW bits.
  - if_ack, output, 1 bit.
REQ-008 The block SHALL have data ports:
  - d_req, input, 1 bit.
  - d_we, input, 1 bit.
  - d_be, input, DW/8 bits.
  - d_addr, input, AW bits.
  - d_wdata, input, DW bits.
  - d_rdata, output, DW bits.
  - d_ack, output, 1 bit.
REQ-009 The block SHALL have memory ports:
  - m_req, output, 1 bit.
  - m_we, output, 1 bit.
  - m_be, output, DW/8 bits.
  - m_addr, output, AW bits.
  - m_wdata, output, DW bits.
  - m_rdata, input, DW bits.
  - m_ready, input, 1 bit.
REQ-010 The block SHALL have status ports busy (output, 1 bit) and err (output, 1 bit).

Function
REQ-011 The block SHALL share one single-ported memory between the instruction-fetch and data-access requesters of the RV32 core.
REQ-012 The block SHALL use a three-state FSM:
  - IDLE moves to ISSUE when either request is high.
  - ISSUE moves to ACK when m_ready is 1.
  - ACK always moves to IDLE.
REQ-013 In IDLE, the block SHALL pick a winner and register the winner's address, write enable, byte enables and write data into the m_* output registers.
REQ-014 All m_* outputs SHALL come from registers; m_req SHALL be 1 exactly while in ISSUE.
REQ-015 Registered m_* fields SHALL stay stable throughout ISSUE, regardless of changes on the requester inputs.
REQ-016 Fetch transactions SHALL drive m_we=0 and m_be all-ones.
REQ-017 In ISSUE with m_ready=1, the block SHALL capture m_rdata into the winner's rdata register, or zero for a write.
REQ-018 In ACK, the winner's ack SHALL be high for exactly one cycle, and the loser's ack SHALL be 0.
REQ-019 if_rdata and d_rdata SHALL hold their last value until overwritten.
REQ-020 With a zero-wait memory (m_ready=1 throughout ISSUE), ack SHALL assert 2 cycles after req is sampled in IDLE, and back-to-back throughput SHALL be 1 transaction per 3 cycles.
REQ-021 Requesters SHALL hold req and fields stable until ack; a req still high in the cycle after ack SHALL be treated as a new request.
REQ-022 Priority SHALL be data over fetch unless the starve counter equals STARVE_MAX, in which case fetch wins.
REQ-023 The starve counter SHALL:
  - increment when data wins while if_req=1;
  - clear when fetch wins or when if_req=0 in IDLE;
  - saturate at STARVE_MAX.
REQ-024 When only one request is high, that requester SHALL win regardless of the counter.
REQ-025 A request that rises during ISSUE or ACK SHALL wait; it SHALL not be lost or merged.
REQ-026 busy SHALL equal (state != IDLE).

Reset
REQ-027 rst=0 SHALL asynchronously force:
  - the FSM to IDLE;
  - the starve counter and timeout counter to 0;
  - all outputs to 0.
REQ-028 A transaction in flight when reset asserts SHALL be discarded with no ack, and m_req SHALL drop immediately.
REQ-029 Reset deassertion SHALL take effect on the first rising clk edge after rst rises.

Configuration
REQ-030 Macro ARB_TIMEOUT_EN: when defined, a counter SHALL run in ISSUE. If it reaches TIMEOUT_CYCLES without m_ready, the block SHALL:
  - drop m_req;
  - enter ACK with the winner's rdata set to 0;
  - pulse err together with ack.
REQ-031 Without ARB_TIMEOUT_EN, ISSUE SHALL wait indefinitely, err SHALL be tied to 0, and no timeout counter SHALL be synthesized.

Structure
REQ-032 Shared package femto_mem_pkg SHALL hold the FSM state type (IDLE/ISSUE/ACK), the default AW/DW, and the STARVE_MAX and TIMEOUT_CYCLES defaults.
REQ-033 Winner selection and the starve counter SHALL live in sub-module mem_arb_pick; the FSM and datapath registers stay in mem_port_arbiter.

Verification
REQ-034 The bench SHALL cover these scenarios:
  - Single fetch: if_req=1 at if_addr=0x0000_0010, m_ready=1, m_rdata=0x0000_0013. Required: m_req high in cycle 1, if_ack in cycle 2, if_rdata=0x0000_0013, d_ack never asserted.
  - Data store: d_req=1, d_we=1, d_be=4'b0011, d_addr=0x100, d_wdata=0xDEAD_BEEF, m_ready delayed 3 cycles. Required: m_* fields stable for all 3 ISSUE cycles, d_ack 1 cycle after m_ready, d_rdata=0.
  - Contention: if_req and d_req held continuously. Required grant order D,D,D,D,F,D,D,D,D,F with STARVE_MAX=4.
  - Simultaneous single requests alternating: fetch wins whenever d_req=0, and the starve counter clears on each fetch win.
  - Reset asserted mid-ISSUE. Required: m_req=0, busy=0, no ack; after release, a new request completes normally.
  - With ARB_TIMEOUT_EN and m_ready held 0. Required: err and d_ack both high in the same single cycle, 16 cycles after ISSUE entry, d_rdata=0, then FSM back to IDLE. Without the macro, err stays 0.
